// File: rtl/inert_ctrl_if.sv
// ---------------------------------------------------------------------------
// inert_ctrl_if
// Command/response handshake between inert_ctrl and the SPI master.
//   wrt     : one-cycle pulse that starts an SPI transaction
//   cmd     : 16-bit word to shift out, held from wrt until done
//   done    : one-cycle pulse marking transaction complete
//   rd_data : 16-bit word shifted in, valid while done=1
// master = inert_ctrl side, slave = SPI master side.
// ---------------------------------------------------------------------------
interface inert_ctrl_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_ctrl.sv
// ---------------------------------------------------------------------------
// inert_ctrl
// Inertial sensor controller. After reset it waits INIT_CYCLES, writes four
// configuration registers, then on each (synchronized) data-ready interrupt
// reads six angle-rate bytes and publishes pitch/roll/yaw atomically.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   INT               : asynchronous data-ready interrupt from the sensor
//   spi (master)      : wrt/cmd out, done/rd_data in
//   ptch, roll, yaw   : latest signed angle-rate samples
//   vld               : one-cycle pulse when ptch/roll/yaw were updated
//   init_done         : level, high once configuration has been written
// ---------------------------------------------------------------------------
module inert_ctrl #(
  parameter logic [15:0] INIT_CYCLES = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                INT,
  inert_ctrl_if.master        spi,
  output logic [15:0]         ptch,
  output logic [15:0]         roll,
  output logic [15:0]         yaw,
  output logic                vld,
  output logic                init_done
);

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG_WRT,
    CFG_WAIT,
    IDLE,
    RD_WRT,
    RD_WAIT,
    VLD
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       cfg_idx_q, cfg_idx_d;
  logic [2:0]       rd_idx_q, rd_idx_d;
  logic [5:0][7:0]  shadow_q, shadow_d;
  logic             wrt_q, wrt_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             vld_q, vld_d;
  logic             init_done_q, init_done_d;
  logic [15:0]      ptch_q, ptch_d;
  logic [15:0]      roll_q, roll_d;
  logic [15:0]      yaw_q, yaw_d;
  logic             int_meta_q, int_sync_q;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_word = 16'h0D02;  // INT pin on data ready
      2'd1:    cfg_word = 16'h1053;  // accel setup
      2'd2:    cfg_word = 16'h1150;  // gyro setup
      default: cfg_word = 16'h1460;  // rounding
    endcase
  endfunction

  // Reads walk registers 0x22..0x27 with the read bit set: pitch L/H, roll L/H, yaw L/H.
  function automatic logic [15:0] rd_word(input logic [2:0] idx);
    rd_word = {8'hA2 + {5'd0, idx}, 8'h00};
  endfunction

  // wrt and cmd are registered and launched on the edge that enters a *_WRT
  // state, so wrt is a clean one-cycle pulse that reset can never glitch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_idx_d   = cfg_idx_q;
    rd_idx_d    = rd_idx_q;
    shadow_d    = shadow_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    ptch_d      = ptch_q;
    roll_d      = roll_q;
    yaw_d       = yaw_q;

    case (state_q)
      INIT_WAIT: begin
        if (cnt_q == INIT_CYCLES) begin
          state_d = CFG_WRT;
          wrt_d   = 1'b1;
          cmd_d   = cfg_word(cfg_idx_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      CFG_WRT: state_d = CFG_WAIT;

      CFG_WAIT: begin
        if (spi.done) begin
          cfg_idx_d = cfg_idx_q + 2'd1;
          if (cfg_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = CFG_WRT;
            wrt_d   = 1'b1;
            cmd_d   = cfg_word(cfg_idx_q + 2'd1);
          end
        end
      end

      IDLE: begin
        if (int_sync_q) begin
          rd_idx_d = 3'd0;
          state_d  = RD_WRT;
          wrt_d    = 1'b1;
          cmd_d    = rd_word(3'd0);
        end
      end

      RD_WRT: state_d = RD_WAIT;

      RD_WAIT: begin
        if (spi.done) begin
          shadow_d[rd_idx_q] = spi.rd_data[7:0];
          if (rd_idx_q == 3'd5) begin
            // All three words load together from the completed shadow set
            // (including the byte arriving now), visible with vld in VLD.
            state_d = VLD;
            vld_d   = 1'b1;
            ptch_d  = {shadow_d[1], shadow_d[0]};
            roll_d  = {shadow_d[3], shadow_d[2]};
            yaw_d   = {shadow_d[5], shadow_d[4]};
          end else begin
            rd_idx_d = rd_idx_q + 3'd1;
            state_d  = RD_WRT;
            wrt_d    = 1'b1;
            cmd_d    = rd_word(rd_idx_q + 3'd1);
          end
        end
      end

      VLD: state_d = IDLE;

      default: state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= 16'd0;
      cfg_idx_q   <= 2'd0;
      rd_idx_q    <= 3'd0;
      shadow_q    <= '0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      ptch_q      <= 16'h0000;
      roll_q      <= 16'h0000;
      yaw_q       <= 16'h0000;
      int_meta_q  <= 1'b0;
      int_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_idx_q   <= cfg_idx_d;
      rd_idx_q    <= rd_idx_d;
      shadow_q    <= shadow_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      ptch_q      <= ptch_d;
      roll_q      <= roll_d;
      yaw_q       <= yaw_d;
      int_meta_q  <= INT;
      int_sync_q  <= int_meta_q;
    end
  end

  assign spi.wrt   = wrt_q;
  assign spi.cmd   = cmd_q;
  assign ptch      = ptch_q;
  assign roll      = roll_q;
  assign yaw       = yaw_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_ctrl.sv
module tb_inert_ctrl;
  localparam logic [15:0] INIT = 16'd20;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic [15:0] ptch, roll, yaw;
  logic        vld, init_done;

  inert_ctrl_if spi ();

  inert_ctrl #(.INIT_CYCLES(INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .spi       (spi),
    .ptch      (ptch),
    .roll      (roll),
    .yaw       (yaw),
    .vld       (vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sensor register contents seen by the reads: index 0..5 = regs 0x22..0x27.
  logic [7:0]  sens [6];
  logic [15:0] cmd_log [$];
  int          wrt_cnt  = 0;
  int          vld_cnt  = 0;
  int          done_cnt = 0;
  int          mark_w   = 0;
  int          mark_v   = 0;
  bit          stray_req = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SPI slave model: answers each wrt with done after 2..5 cycles.
  initial begin : responder
    bit          busy = 0;
    bit          tainted = 0;
    int          lat = 0;
    logic [15:0] cur_cmd = 16'h0;
    logic [15:0] rdv;
    spi.done    = 1'b0;
    spi.rd_data = 16'h0;
    forever begin
      @(negedge clk);
      spi.done = 1'b0;
      if (vld === 1'b1) vld_cnt++;
      if (rst === 1'b1 && busy) tainted = 1;
      if (spi.wrt === 1'b1) begin
        check("wrt_while_busy", 32'(busy), 32'd0);
        cmd_log.push_back(spi.cmd);
        cur_cmd = spi.cmd;
        busy    = 1;
        tainted = 0;
        lat     = int'($urandom_range(2, 5));
        wrt_cnt++;
      end else if (busy) begin
        if (!tainted) check("cmd_stable", 32'(spi.cmd), 32'(cur_cmd));
        lat--;
        if (lat == 0) begin
          if (cur_cmd[15:8] >= 8'hA2 && cur_cmd[15:8] <= 8'hA7)
            rdv = {8'($urandom), sens[cur_cmd[10:8] - 3'd2]};
          else
            rdv = 16'($urandom);
          spi.done    = 1'b1;
          spi.rd_data = rdv;
          busy        = 0;
          done_cnt++;
          $display("txn cmd=%h rd_data=%h", cur_cmd, rdv);
        end
      end else if (stray_req) begin
        spi.done    = 1'b1;
        spi.rd_data = 16'($urandom);
        stray_req   = 0;
        $display("txn stray done rd_data=%h", spi.rd_data);
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    INT = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ptch", 32'(ptch), 32'd0);
    check("rst_roll", 32'(roll), 32'd0);
    check("rst_yaw", 32'(yaw), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_wrt", 32'(spi.wrt), 32'd0);
    check("rst_cmd", 32'(spi.cmd), 32'd0);
    cmd_log.delete();
    rst = 1'b0;
  endtask

  // Counts cycles from reset release to first wrt, then follows the config writes.
  task automatic init_and_config(input string tag);
    int n;
    bit got;
    logic [15:0] exp_cfg [4];
    exp_cfg[0] = 16'h0D02; exp_cfg[1] = 16'h1053;
    exp_cfg[2] = 16'h1150; exp_cfg[3] = 16'h1460;
    got = 0;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 10) done_cnt = 0;  // in-flight pre-reset transactions are over by now
      if (spi.wrt === 1'b1) begin got = 1; break; end
    end
    check({tag, "_first_wrt_seen"}, 32'(got), 32'd1);
    check({tag, "_first_wrt_cycle"}, 32'(n), 32'(INIT) + 32'd1);
    check({tag, "_first_cmd"}, 32'(spi.cmd), 32'h0D02);
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin got = 1; break; end
    end
    check({tag, "_init_done_rise"}, 32'(got), 32'd1);
    check({tag, "_dones_at_init_done"}, 32'(done_cnt), 32'd4);
    check({tag, "_cfg_count"}, 32'(cmd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < cmd_log.size())
        check($sformatf("%s_cfg_cmd%0d", tag, i), 32'(cmd_log[i]), 32'(exp_cfg[i]));
    cmd_log.delete();
    mark_w = wrt_cnt;
    mark_v = vld_cnt;
  endtask

  // One read sequence: expected outputs come from the sensor byte model.
  // hold=1 keeps INT high; noise=1 pulses INT while reads are outstanding.
  task automatic run_sample(input string tag, input bit hold, input bit noise);
    logic [15:0] ep, er, ey;
    bit seen;
    ep = {sens[1], sens[0]};
    er = {sens[3], sens[2]};
    ey = {sens[5], sens[4]};
    seen = 0;
    INT = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (!hold) INT = noise && (i == 6 || i == 11);
      if (vld === 1'b1) begin seen = 1; break; end
    end
    check({tag, "_vld_seen"}, 32'(seen), 32'd1);
    check({tag, "_ptch"}, 32'(ptch), 32'(ep));
    check({tag, "_roll"}, 32'(roll), 32'(er));
    check({tag, "_yaw"}, 32'(yaw), 32'(ey));
    check({tag, "_wrt_per_vld"}, 32'(wrt_cnt - mark_w), 32'd6);
    check({tag, "_rd_count"}, 32'(cmd_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < cmd_log.size())
        check($sformatf("%s_rd_cmd%0d", tag, i), 32'(cmd_log[i]), 32'h0000A200 + 32'(i) * 32'h100);
    cmd_log.delete();
    mark_w = wrt_cnt;
    @(negedge clk);
    check({tag, "_vld_pulse_count"}, 32'(vld_cnt - mark_v), 32'd1);
    check({tag, "_vld_one_cycle"}, 32'(vld), 32'd0);
    check({tag, "_idle_no_wrt"}, 32'(spi.wrt), 32'd0);
    mark_v = vld_cnt;
  endtask

  task automatic randomize_sens();
    for (int i = 0; i < 6; i++) sens[i] = 8'($urandom);
  endtask

  initial begin : main
    logic [15:0] hp, hr, hy;
    bit got;
    rst = 1'b1;
    INT = 1'b0;
    for (int i = 0; i < 6; i++) sens[i] = 8'h00;

    apply_reset();
    init_and_config("boot");

    // Known sensor samples.
    randomize_sens(); sens[0] = 8'h63; sens[1] = 8'h56;
    run_sample("s1", 0, 0);
    randomize_sens(); sens[0] = 8'h0D; sens[1] = 8'hCD;
    run_sample("s2", 0, 0);

    for (int k = 0; k < 3; k++) begin
      randomize_sens();
      run_sample($sformatf("rand%0d", k), 0, 0);
    end

    // INT activity while reads are outstanding must not add reads.
    randomize_sens();
    run_sample("noise", 0, 1);
    repeat (20) @(negedge clk);
    check("noise_no_extra_wrt", 32'(wrt_cnt - mark_w), 32'd0);

    // Stray done while idle.
    hp = ptch; hr = roll; hy = yaw;
    stray_req = 1;
    repeat (10) @(negedge clk);
    check("stray_no_vld", 32'(vld_cnt - mark_v), 32'd0);
    check("stray_no_wrt", 32'(wrt_cnt - mark_w), 32'd0);
    check("stray_ptch", 32'(ptch), 32'(hp));
    check("stray_roll", 32'(roll), 32'(hr));
    check("stray_yaw", 32'(yaw), 32'(hy));
    randomize_sens();
    run_sample("after_stray", 0, 0);

    // INT held high: back-to-back sequences, one IDLE cycle between.
    randomize_sens();
    run_sample("held0", 1, 0);
    randomize_sens();
    @(negedge clk);
    check("held_gap_wrt", 32'(spi.wrt), 32'd1);
    run_sample("held1", 1, 0);
    INT = 1'b0;
    @(negedge clk);
    check("held_gap_wrt2", 32'(spi.wrt), 32'd1);

    // Reset during the third read transaction of the trailing sequence.
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wrt_cnt - mark_w >= 3) begin got = 1; break; end
    end
    check("mid_third_wrt", 32'(got), 32'd1);
    @(negedge clk);
    apply_reset();
    init_and_config("reinit");
    randomize_sens();
    run_sample("post_reset", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inert_ctrl.md
INERT_CTRL -- requirements
Module: inert_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 16'hFFFF: clk cycles to wait after reset before the first SPI command.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 INT  input  1  asynchronous data-ready interrupt from the inertial sensor.
REQ-005 done  input  1  single-cycle pulse from SPI_mnrch marking transaction complete.
REQ-006 rd_data  input  16  SPI_mnrch read data; valid in the cycle done=1.
REQ-007 wrt  output  1  single-cycle pulse starting an SPI_mnrch transaction.
REQ-008 cmd  output  16  SPI_mnrch wrt_data; held stable from wrt until done.
REQ-009 ptch, roll, yaw  output  16 each  latest signed angle-rate samples.
REQ-010 vld  output  1  single-cycle pulse: ptch/roll/yaw updated.
REQ-011 init_done  output  1  level, high once configuration writes finish.

Function
REQ-012 INT SHALL pass through a 2-flop synchronizer; only the synchronized level is used.
REQ-013 States SHALL be INIT_WAIT, CFG_WRT, CFG_WAIT, IDLE, RD_WRT, RD_WAIT, VLD.
REQ-014 INIT_WAIT: a 16-bit counter increments each cycle; at count == INIT_CYCLES go to CFG_WRT.
REQ-015 Config sequence, index 0..3, SHALL issue: 16'h0D02 (INT on data ready), 16'h1053 (accel), 16'h1150 (gyro), 16'h1460 (rounding).
REQ-016 CFG_WRT: assert wrt for one cycle with cmd = current config word, then go to CFG_WAIT.
REQ-017 CFG_WAIT: on done, increment index; if the index was 3, set init_done and go to IDLE, else go to CFG_WRT.
REQ-018 IDLE: when synchronized INT = 1, go to RD_WRT with read index 0; otherwise stay.
REQ-019 Read sequence, index 0..5, SHALL issue: 16'hA200, A300, A400, A500, A600, A700 (pitch L/H, roll L/H, yaw L/H).
REQ-020 RD_WRT: one-cycle wrt with cmd = current read word, then go to RD_WAIT.
REQ-021 RD_WAIT: on done, capture rd_data[7:0] into a shadow byte for that index; if the index was 5, go to VLD, else increment the index and go to RD_WRT.
REQ-022 VLD: load ptch/roll/yaw from the shadow bytes as {high, low} in one cycle, pulse vld, return to IDLE.
- vld occurs the cycle after the 6th done.
- Outputs never show a partially updated sample.
REQ-023 INT changes outside IDLE SHALL be ignored. If INT is still high on return to IDLE, a new read sequence SHALL start on the next cycle (level-sensitive).
REQ-024 wrt SHALL never be asserted while a transaction is outstanding (between wrt and its done).
REQ-025 done arriving in any state other than CFG_WAIT or RD_WAIT SHALL be ignored.
REQ-026 cmd SHALL keep its last value between transactions.

Reset
REQ-027 When rst = 1 at a clk edge, the following SHALL take effect on that edge:
- state INIT_WAIT; counter, indices and shadow bytes cleared.
- wrt=0, vld=0, init_done=0, cmd=16'h0000.
- ptch=roll=yaw=16'h0000; synchronizer flops cleared.
REQ-028 Reset mid-transaction SHALL abandon the sequence without a wrt glitch. INIT_CYCLES SHALL exceed one SPI transaction length, so any in-flight transaction completes before the first post-reset wrt.

Verification
REQ-029 Reset, then count INIT_CYCLES -> first wrt, with cmd=16'h0D02, occurs exactly INIT_CYCLES+1 cycles after rst deasserts; 4 config wrt pulses in order; init_done rises after the 4th done.
REQ-030 Run with SPI_mnrch + SPI_iNEMO1 model:
- first INT -> vld with ptch=16'h5663.
- second INT -> vld with ptch=16'hCD0D.
REQ-031 INT pulses during RD_WAIT -> no extra wrt; exactly 6 wrt per vld.
REQ-032 INT held high continuously -> back-to-back sequences, with IDLE lasting one cycle between VLD and the next wrt.
REQ-033 Assert rst during the 3rd read transaction:
- outputs zero, init_done=0.
- full init and config repeat.
- no wrt before INIT_CYCLES elapse.
REQ-034 Stray done pulse injected in IDLE -> no state change, no capture, no vld.
